// File: rtl/audio_controller.sv
// Sound-effect generator: a hit/miss event plays a fixed-length square-wave tone as PWM audio.
// Optional feature macro: AUDIO_MISS_TONE_EN enables the miss tone on hit==2.
module audio_controller #(
    parameter int TONE_CYCLES      = 2500000,
    parameter int HIT_HALF_PERIOD  = 12500,
    parameter int MISS_HALF_PERIOD = 50000,
    parameter int PWM_BITS         = 8,
    parameter int VOLUME           = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] hit,
    output logic       chSel,
    output logic       audioOut,
    output logic       audioEn
);

    localparam int HALF_MAX = (HIT_HALF_PERIOD > MISS_HALF_PERIOD) ? HIT_HALF_PERIOD : MISS_HALF_PERIOD;
    localparam int DUR_W    = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
    localparam int HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [DUR_W-1:0]    DUR_LAST  = DUR_W'(TONE_CYCLES - 1);
    localparam logic [HALF_W-1:0]   HIT_LAST  = HALF_W'(HIT_HALF_PERIOD - 1);
    localparam logic [HALF_W-1:0]   MISS_LAST = HALF_W'(MISS_HALF_PERIOD - 1);
    localparam logic [PWM_BITS-1:0] LEVEL     = PWM_BITS'(VOLUME);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                trigger;
    logic                tone_done;
    logic                tone_miss;
    logic                phase;
    logic [DUR_W-1:0]    dur_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic [HALF_W-1:0]   half_last;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] sample;

`ifdef AUDIO_MISS_TONE_EN
    assign trigger = (hit == 2'd1) || (hit == 2'd2);
`else
    assign trigger = (hit == 2'd1);
`endif

    assign tone_done = (dur_cnt == DUR_LAST);
    assign half_last = tone_miss ? MISS_LAST : HIT_LAST;
    assign sample    = phase ? LEVEL : '0;
    assign chSel     = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A trigger always wins, even on the final cycle of a tone.
    always_comb begin
        state_next = state;
        audioEn    = (state == PLAY);
        if (trigger) begin
            state_next = PLAY;
        end else if ((state == PLAY) && tone_done) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tone_miss <= 1'b0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
        end else if (trigger) begin
            tone_miss <= (hit == 2'd2);
            dur_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b1;
        end else if (state_next == PLAY) begin
            dur_cnt <= dur_cnt + 1'b1;
            if (half_cnt == half_last) begin
                half_cnt <= '0;
                phase    <= ~phase;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end else begin
            dur_cnt  <= '0;
            half_cnt <= '0;
            phase    <= 1'b0;
        end
    end

    // PWM carrier runs continuously so retriggers never disturb its phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt  <= '0;
            audioOut <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            audioOut <= (state_next == PLAY) && (pwm_cnt < sample);
        end
    end

endmodule

// File: tb/tb_audio_controller.sv
// Self-checking bench for audio_controller: a cycle model pushes expected outputs to a scoreboard
// queue on every clock edge, and each entry is popped and compared half a cycle later.
module tb_audio_controller;

    localparam int TONE = 64;
    localparam int HITH = 4;
    localparam int MISSH = 8;
    localparam int PWMB = 4;
    localparam int VOL = 8;

`ifdef AUDIO_MISS_TONE_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    typedef struct packed {
        logic en;
        logic out;
        logic qout;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] hit;
    logic       chSel;
    logic       audioOut;
    logic       audioEn;
    logic       qChSel;
    logic       qAudioOut;
    logic       qAudioEn;

    int   checks;
    int   errors;
    exp_t sb[$];

    int mRem;
    int mEl;
    int mPwm;
    bit mMiss;

    audio_controller #(
        .TONE_CYCLES(TONE), .HIT_HALF_PERIOD(HITH), .MISS_HALF_PERIOD(MISSH),
        .PWM_BITS(PWMB), .VOLUME(VOL)
    ) dut (
        .clk(clk), .reset(reset), .hit(hit),
        .chSel(chSel), .audioOut(audioOut), .audioEn(audioEn)
    );

    audio_controller #(
        .TONE_CYCLES(TONE), .HIT_HALF_PERIOD(HITH), .MISS_HALF_PERIOD(MISSH),
        .PWM_BITS(PWMB), .VOLUME(0)
    ) dut_quiet (
        .clk(clk), .reset(reset), .hit(hit),
        .chSel(qChSel), .audioOut(qAudioOut), .audioEn(qAudioEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: a tone is a countdown of remaining cycles, and the square-wave phase
    // follows from time elapsed since the trigger divided by the half period.
    task automatic modelEdge();
        exp_t e;
        int   hp;
        int   remNext;
        int   elNext;
        bit   ph;
        bit   trig;
        e = '0;
        if (reset) begin
            mRem = 0;
            mEl = 0;
            mPwm = 0;
            mMiss = 1'b0;
        end else begin
            hp   = mMiss ? MISSH : HITH;
            ph   = (mRem > 0) && (((mEl / hp) % 2) == 0);
            trig = (hit == 2'd1) || (MISS_EN && (hit == 2'd2));
            if (trig) begin
                remNext = TONE;
                elNext  = 0;
                mMiss   = (hit == 2'd2);
            end else begin
                remNext = (mRem > 0) ? mRem - 1 : 0;
                elNext  = mEl + 1;
            end
            e.en   = (remNext > 0);
            e.out  = e.en && (mPwm < (ph ? VOL : 0));
            e.qout = 1'b0;
            mPwm = (mPwm + 1) % (1 << PWMB);
            mRem = remNext;
            mEl  = elNext;
        end
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compare("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            compare("audioEn", int'(audioEn), int'(e.en));
            compare("audioOut", int'(audioOut), int'(e.out));
            compare("chSel", int'(chSel), 0);
            compare("quiet_audioEn", int'(qAudioEn), int'(e.en));
            compare("quiet_audioOut", int'(qAudioOut), int'(e.qout));
        end
    endtask

    task automatic applyStimulus(input logic [1:0] h, input logic r);
        hit   = h;
        reset = r;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runIdle(input int n, output int enCount);
        enCount = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(2'd0, 1'b0);
            if (audioEn === 1'b1) enCount++;
        end
    endtask

    initial begin
        int cnt;
        int cnt2;
        checks = 0;
        errors = 0;
        mRem = 0;
        mEl = 0;
        mPwm = 0;
        mMiss = 1'b0;
        hit = 2'd1;
        reset = 1'b1;

        $display("[TB] reset held with hit=1");
        for (int i = 0; i < 3; i++) applyStimulus(2'd1, 1'b1);
        runIdle(3, cnt);
        compare("reset_idle_en_count", cnt, 0);

        $display("[TB] hit tone");
        applyStimulus(2'd1, 1'b0);
        cnt = (audioEn === 1'b1) ? 1 : 0;
        runIdle(70, cnt2);
        compare("hit_en_cycles", cnt + cnt2, TONE);

        $display("[TB] miss tone");
        applyStimulus(2'd2, 1'b0);
        cnt = (audioEn === 1'b1) ? 1 : 0;
        runIdle(70, cnt2);
        compare("miss_en_cycles", cnt + cnt2, MISS_EN ? TONE : 0);

        $display("[TB] retrigger hit then miss");
        applyStimulus(2'd1, 1'b0);
        cnt = (audioEn === 1'b1) ? 1 : 0;
        runIdle(29, cnt2);
        cnt += cnt2;
        applyStimulus(2'd2, 1'b0);
        if (audioEn === 1'b1) cnt++;
        runIdle(100, cnt2);
        compare("retrigger_en_cycles", cnt + cnt2, MISS_EN ? (30 + TONE) : TONE);

        $display("[TB] ignored code 3");
        applyStimulus(2'd3, 1'b0);
        cnt = (audioEn === 1'b1) ? 1 : 0;
        runIdle(10, cnt2);
        compare("code3_en_cycles", cnt + cnt2, 0);

        $display("[TB] reset mid-tone");
        applyStimulus(2'd1, 1'b0);
        runIdle(10, cnt);
        applyStimulus(2'd0, 1'b1);
        compare("abort_en", int'(audioEn), 0);
        compare("abort_out", int'(audioOut), 0);
        runIdle(20, cnt);
        compare("abort_no_restart", cnt, 0);

        $display("[TB] back-to-back hit after idle");
        applyStimulus(2'd1, 1'b0);
        runIdle(TONE + 4, cnt);
        compare("final_hit_en_cycles", cnt, TONE - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
